br_lite_local_arbiter: RTL



---
 rtl/br_lite_local_arbiter_pkg.sv | 42 ++++
 rtl/br_lite_rr_arbiter.sv | 30 +++
 rtl/br_lite_local_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/br_lite_local_arbiter_pkg.sv
// BrLite shared types: flit layout, service codes, local-port index, arbiter states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package br_lite_local_arbiter_pkg;

  // Flit payload width and rolling-id width (the id wraps modulo 2**BR_ID_W)
  localparam int BR_PAYLOAD_W = 32;
  localparam int BR_ID_W      = 8;

  // Router port index of the PE-side local port
  localparam int BR_LOCAL = 4;

  // REQ-phase watchdog default, used only when the timeout feature is built in
  localparam int BR_ARB_TIMEOUT_DEFAULT = 1024;

  // Service carried by a flit; all four codes are defined so any 2-bit value is legal
  typedef enum logic [1:0] {
    BR_SVC_MSG = 2'd0,
    BR_SVC_REQ = 2'd1,
    BR_SVC_RSP = 2'd2,
    BR_SVC_CLR = 2'd3
  } br_service_t;

  typedef struct packed {
    logic [15:0]             seq_source;
    logic [15:0]             seq_target;
    br_service_t             service;
    logic [BR_PAYLOAD_W-1:0] payload;
    logic [BR_ID_W-1:0]      id;
  } br_data_t;

  // Local-arbiter transaction phases
  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_WAIT_FREE = 3'd1,
    ARB_CAPTURE   = 3'd2,
    ARB_REQ       = 3'd3,
    ARB_RELEASE   = 3'd4,
    ARB_DONE      = 3'd5
  } br_arb_state_t;

endpackage

// File: rtl/br_lite_rr_arbiter.sv
// Round-robin pick: first asserted request strictly after the pointer, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when to accept the pick and move the pointer.
module br_lite_rr_arbiter #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_gnt_vld,
  output logic [IDX_W-1:0] o_gnt_idx
);

  logic [IDX_W-1:0] w_pos;

  // Scan offsets from farthest to nearest so the nearest requester after the pointer wins
  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt_idx = '0;
    w_pos     = '0;
    for (int d = NREQ; d >= 1; d--) begin
      w_pos = IDX_W'((int'(i_ptr) + d) % NREQ);
      if (i_req[w_pos]) begin
        o_gnt_vld = 1'b1;
        o_gnt_idx = w_pos;
      end
    end
  end

endmodule

// File: rtl/br_lite_local_arbiter.sv
// Shares the router LOCAL port among NREQ PE requesters: round-robin pick, flit stamping, 4-phase req/ack.
// Latency: valid->ready 2 cycles when the router is free; minimum transaction 5 cycles plus router ack time.
// Backpressure: router busy holds off new grants; req stays high with a frozen flit until ack.
// Optional build macro BRLITE_LOCAL_ARB_TIMEOUT_EN adds TIMEOUT_CYCLES and timeout_o (REQ watchdog).
module br_lite_local_arbiter
  import br_lite_local_arbiter_pkg::*;
#(
  parameter int          NREQ        = 4,
  parameter logic [15:0] SEQ_ADDRESS = 16'h0000
`ifdef BRLITE_LOCAL_ARB_TIMEOUT_EN
  , parameter int        TIMEOUT_CYCLES = BR_ARB_TIMEOUT_DEFAULT
`endif
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NREQ-1:0]                      src_valid_i,
  output logic [NREQ-1:0]                      src_ready_o,
  input  logic [NREQ-1:0][15:0]                src_target_i,
  input  br_service_t [NREQ-1:0]               src_service_i,
  input  logic [NREQ-1:0][BR_PAYLOAD_W-1:0]    src_payload_i,
  output logic [NREQ-1:0]                      src_done_o,
  input  logic                                 busy_i,
  output br_data_t                             flit_o,
  output logic                                 req_o,
  input  logic                                 ack_i,
`ifdef BRLITE_LOCAL_ARB_TIMEOUT_EN
  output logic                                 timeout_o,
`endif
  output logic [$clog2(NREQ)-1:0]              grant_idx_o
);

  localparam int IDX_W = $clog2(NREQ);

  br_arb_state_t       r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_gidx;
  logic [BR_ID_W-1:0]  r_id;
  logic                r_req;
  logic [NREQ-1:0]     r_ready;
  logic [NREQ-1:0]     r_done;
  br_data_t            r_flit;
`ifdef BRLITE_LOCAL_ARB_TIMEOUT_EN
  logic [15:0]         r_to_cnt;
  logic                r_timeout;
`endif

  logic                w_win_vld;
  logic [IDX_W-1:0]    w_win_idx;

  br_lite_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .i_req     (src_valid_i),
    .i_ptr     (r_ptr),
    .o_gnt_vld (w_win_vld),
    .o_gnt_idx (w_win_idx)
  );

  // Transaction FSM; every output is a register so the router sees glitch-free req/flit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ARB_IDLE;
      r_ptr    <= IDX_W'(NREQ - 1);
      r_gidx   <= '0;
      r_id     <= '0;
      r_req    <= 1'b0;
      r_ready  <= '0;
      r_done   <= '0;
      r_flit   <= '0;
`ifdef BRLITE_LOCAL_ARB_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      // ready/done/timeout are single-cycle pulses
      r_ready <= '0;
      r_done  <= '0;
`ifdef BRLITE_LOCAL_ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        ARB_IDLE: begin
          // ack_i here is spurious and deliberately not looked at
          if (|src_valid_i) begin
            r_state <= busy_i ? ARB_WAIT_FREE : ARB_CAPTURE;
          end
        end
        ARB_WAIT_FREE: begin
          // Nothing is latched while waiting; the pick is redone once free
          if (!busy_i) begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_CAPTURE: begin
          // A requester may have withdrawn since IDLE; with nobody left, fall back
          if (w_win_vld) begin
            r_flit <= '{seq_source: SEQ_ADDRESS,
                        seq_target: src_target_i[w_win_idx],
                        service:    src_service_i[w_win_idx],
                        payload:    src_payload_i[w_win_idx],
                        id:         r_id};
            r_ready[w_win_idx] <= 1'b1;
            r_ptr   <= w_win_idx;
            r_gidx  <= w_win_idx;
            r_id    <= r_id + BR_ID_W'(1);
            r_req   <= 1'b1;
`ifdef BRLITE_LOCAL_ARB_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
            r_state <= ARB_REQ;
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_REQ: begin
          // A CAM-full router just drops back to init; keep req and flit steady so it retries
          if (ack_i) begin
            r_req   <= 1'b0;
            r_state <= ARB_RELEASE;
`ifdef BRLITE_LOCAL_ARB_TIMEOUT_EN
          end else if (r_to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            // Give up: no done pulse, and the consumed id stays consumed
            r_req     <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ARB_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
`endif
          end
        end
        ARB_RELEASE: begin
          if (!ack_i) begin
            r_done[r_gidx] <= 1'b1;
            r_state        <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          r_state <= ARB_IDLE;
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign src_ready_o = r_ready;
  assign src_done_o  = r_done;
  assign flit_o      = r_flit;
  assign req_o       = r_req;
  assign grant_idx_o = r_gidx;
`ifdef BRLITE_LOCAL_ARB_TIMEOUT_EN
  assign timeout_o   = r_timeout;
`endif

endmodule
